iserdes_calib_ctrl_mc: RTL

ISERDES_CALIB_CTRL_MC -- requirements
Module: iserdes_calib_ctrl_mc

---
 rtl/iserdes_calib_ctrl_mc.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/iserdes_calib_ctrl_mc.sv
// iserdes_calib_ctrl_mc: lock-step multi-channel ISERDES IDELAY/bitslip calibration sequencer.
// Optional macro ISERDES_CALIB_INV_EN enables the per-line inversion flag taken from INV_LINE_MASK.
`default_nettype none

module iserdes_calib_ctrl_mc #(
  parameter int                   NUM_CH        = 2,
  parameter int                   NUM_LINES     = 12,
  parameter int                   MAX_SLIP      = 8,
  parameter int                   TIMEOUT_CYC   = 1023,
  parameter logic [NUM_LINES-1:0] INV_LINE_MASK = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] calib_done_i,
  input  logic [NUM_CH-1:0] calib_fail_i,
  output logic              en_calib_o,
  output logic [NUM_CH-1:0] bitslip_o,
  output logic [7:0]        line_idx_o,
  output logic              use_inv_o,
  output logic              calib_complete_o,
  output logic              calib_error_o,
  output logic [NUM_CH-1:0] err_ch_o
);

  typedef enum logic [6:0] {
    IDLE       = 7'b0000001,
    EN_CALIB   = 7'b0000010,
    WAIT_CALIB = 7'b0000100,
    BITSLIP    = 7'b0001000,
    NEXT_LINE  = 7'b0010000,
    COMPLETE   = 7'b0100000,
    ERROR      = 7'b1000000
  } state_t;

  state_t                 state_q, state_d;
  logic                   en_calib_q, en_calib_d;
  logic [NUM_CH-1:0]      bitslip_q, bitslip_d;
  logic [7:0]             line_idx_q, line_idx_d;
  logic                   complete_q, complete_d;
  logic                   error_q, error_d;
  logic [NUM_CH-1:0]      err_ch_q, err_ch_d;
  logic [15:0]            tmo_q, tmo_d;
  logic [NUM_CH-1:0][3:0] slip_q, slip_d;

  logic [NUM_CH-1:0]      resolved;
  logic [NUM_CH-1:0]      slip_hit;

  always_comb begin
    resolved = calib_done_i | calib_fail_i;
    // A channel hits its limit on the slip being issued right now
    for (int c = 0; c < NUM_CH; c++) begin
      slip_hit[c] = bitslip_q[c] && ((slip_q[c] + 4'd1) == 4'(MAX_SLIP));
    end
  end

  always_comb begin
    state_d    = state_q;
    en_calib_d = en_calib_q;
    bitslip_d  = '0;
    line_idx_d = line_idx_q;
    complete_d = complete_q;
    error_d    = error_q;
    err_ch_d   = err_ch_q;
    tmo_d      = tmo_q;
    slip_d     = slip_q;

    case (state_q)
      IDLE: begin
        en_calib_d = 1'b0;
        state_d    = EN_CALIB;
      end
      EN_CALIB: begin
        en_calib_d = 1'b1;
        tmo_d      = '0;
        state_d    = WAIT_CALIB;
      end
      WAIT_CALIB: begin
        // Resolution on the limit cycle wins over the timeout
        if (&resolved) begin
          en_calib_d = 1'b0;
          if (|calib_fail_i) begin
            bitslip_d = calib_fail_i;
            state_d   = BITSLIP;
          end else begin
            state_d = NEXT_LINE;
          end
        end else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
          en_calib_d = 1'b0;
          err_ch_d   = ~resolved;
          error_d    = 1'b1;
          state_d    = ERROR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      BITSLIP: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (bitslip_q[c]) slip_d[c] = slip_q[c] + 4'd1;
        end
        if (|slip_hit) begin
          err_ch_d = slip_hit;
          error_d  = 1'b1;
          state_d  = ERROR;
        end else begin
          state_d = IDLE;
        end
      end
      NEXT_LINE: begin
        slip_d = '0;
        if (line_idx_q == 8'(NUM_LINES - 1)) begin
          complete_d = 1'b1;
          state_d    = COMPLETE;
        end else begin
          line_idx_d = line_idx_q + 8'd1;
          state_d    = IDLE;
        end
      end
      COMPLETE, ERROR: begin
        if (start_i) begin
          complete_d = 1'b0;
          error_d    = 1'b0;
          err_ch_d   = '0;
          line_idx_d = '0;
          slip_d     = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        en_calib_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      en_calib_q <= 1'b0;
      bitslip_q  <= '0;
      line_idx_q <= '0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
      err_ch_q   <= '0;
      tmo_q      <= '0;
      slip_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_calib_q <= en_calib_d;
      bitslip_q  <= bitslip_d;
      line_idx_q <= line_idx_d;
      complete_q <= complete_d;
      error_q    <= error_d;
      err_ch_q   <= err_ch_d;
      tmo_q      <= tmo_d;
      slip_q     <= slip_d;
    end
  end

`ifdef ISERDES_CALIB_INV_EN
  logic                 use_inv_q, use_inv_d;
  logic [NUM_LINES-1:0] inv_shift;

  always_comb begin
    inv_shift = INV_LINE_MASK >> line_idx_q;
    use_inv_d = inv_shift[0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) use_inv_q <= 1'b0;
    else          use_inv_q <= use_inv_d;
  end

  assign use_inv_o = use_inv_q;
`else
  assign use_inv_o = 1'b0 & (|INV_LINE_MASK);
`endif

  assign en_calib_o       = en_calib_q;
  assign bitslip_o        = bitslip_q;
  assign line_idx_o       = line_idx_q;
  assign calib_complete_o = complete_q;
  assign calib_error_o    = error_q;
  assign err_ch_o         = err_ch_q;

endmodule

`default_nettype wire
